// File: rtl/prime_search_controller.sv
// Prime search controller: requests random candidates and trial-divides each one until a prime is found.
// Optional build macro PRIME_SEARCH_STATS_EN adds the attempts output (tries used by the last search).
module prime_search_controller #(
  parameter int unsigned MAX_TRIES  = 8,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gen_enable,
  input  logic       cand_valid,
  input  logic [6:0] cand,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [6:0] prime
`ifdef PRIME_SEARCH_STATS_EN
  ,
  output logic [3:0] attempts
`endif
);

  localparam int unsigned NUM_W    = 7;
  localparam int unsigned TRY_W    = 4;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned WAIT_W   = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [TRY_W-1:0]   tries, tries_next;
  logic [NUM_W-1:0]   num, num_next;
  logic [NUM_W-1:0]   rem, rem_next;
  logic [IDX_W-1:0]   d_idx, idx_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic [NUM_W-1:0]   prime_next;
  logic               fail_next;
  logic [NUM_W-1:0]   d;

  // Divisor table; 11 is the largest prime not above sqrt(127)
  function automatic logic [NUM_W-1:0] divisor(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    divisor = 7'd2;
      3'd1:    divisor = 7'd3;
      3'd2:    divisor = 7'd5;
      3'd3:    divisor = 7'd7;
      default: divisor = 7'd11;
    endcase
  endfunction

  assign d = divisor(d_idx);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tries      <= '0;
      num        <= '0;
      rem        <= '0;
      d_idx      <= '0;
      wait_cnt   <= '0;
      prime      <= '0;
      fail       <= 1'b0;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      tries      <= tries_next;
      num        <= num_next;
      rem        <= rem_next;
      d_idx      <= idx_next;
      wait_cnt   <= wait_next;
      prime      <= prime_next;
      fail       <= fail_next;
      gen_enable <= (state_next == REQ);
      busy       <= (state_next != IDLE);
      done       <= (state_next == FIN);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    tries_next = tries;
    num_next   = num;
    rem_next   = rem;
    idx_next   = d_idx;
    wait_next  = wait_cnt;
    prime_next = prime;
    fail_next  = fail;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          tries_next = '0;
          prime_next = '0;
          fail_next  = 1'b0;
        end
      end
      REQ: begin
        tries_next = tries + TRY_W'(1);
        wait_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (cand_valid) begin
          num_next   = cand;
          rem_next   = cand;
          idx_next   = '0;
          state_next = CHECK;
        end else if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) begin
          fail_next  = 1'b1;
          prime_next = '0;
          state_next = FIN;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      CHECK: begin
        if (num < NUM_W'(2)) begin
          state_next = NEXT;
        end else if (num == d) begin
          prime_next = num;
          fail_next  = 1'b0;
          state_next = FIN;
        end else if (rem >= d) begin
          rem_next = rem - d;
        end else if (rem == '0) begin
          state_next = NEXT;
        end else if (d_idx == LAST_IDX) begin
          prime_next = num;
          fail_next  = 1'b0;
          state_next = FIN;
        end else begin
          idx_next = d_idx + IDX_W'(1);
          rem_next = num;
        end
      end
      NEXT: begin
        if (tries == TRY_W'(MAX_TRIES)) begin
          fail_next  = 1'b1;
          prime_next = '0;
          state_next = FIN;
        end else begin
          state_next = REQ;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PRIME_SEARCH_STATS_EN
  // Tries used by the last search, captured as the search finishes
  always_ff @(posedge clk) begin
    if (!rst) begin
      attempts <= '0;
    end else if (state == IDLE && start) begin
      attempts <= '0;
    end else if (state_next == FIN) begin
      attempts <= tries;
    end
  end
`endif

endmodule

// File: tb/tb_prime_search_controller.sv
// Self-checking bench for prime_search_controller: generator model plus scoreboard of expected results.
module tb_prime_search_controller;

  localparam int unsigned MAX_TRIES  = 8;
  localparam int unsigned WAIT_LIMIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gen_enable;
  logic       cand_valid;
  logic [6:0] cand;
  logic       busy;
  logic       done;
  logic       fail;
  logic [6:0] prime;
`ifdef PRIME_SEARCH_STATS_EN
  logic [3:0] attempts;
`endif

  prime_search_controller #(
    .MAX_TRIES (MAX_TRIES),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gen_enable(gen_enable),
    .cand_valid(cand_valid),
    .cand      (cand),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .prime     (prime)
`ifdef PRIME_SEARCH_STATS_EN
    ,
    .attempts  (attempts)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       fail;
    logic [6:0] prime;
    int         gens;
    logic [3:0] att;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] cand_q[$];
  int         gen_cyc[$];
  int         gen_count   = 0;
  int         gen_cnt     = 0;
  bit         gen_respond = 1'b1;

  // Generator model: answers each gen_enable pulse two cycles later with the next queued candidate
  initial begin
    cand_valid = 1'b0;
    cand       = '0;
    forever begin
      @(negedge clk);
      cand_valid = 1'b0;
      if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0 && gen_respond && cand_q.size() > 0) begin
          cand       = cand_q.pop_front();
          cand_valid = 1'b1;
        end
      end
      if (gen_enable === 1'b1) begin
        gen_cnt = 2;
        gen_count++;
        gen_cyc.push_back(cyc);
      end
    end
  end

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference result for the candidates currently queued for the generator
  task automatic push_expected();
    exp_t e;
    bit   found;
    e.fail  = 1'b1;
    e.prime = '0;
    e.gens  = 0;
    e.att   = '0;
    found   = 1'b0;
    for (int i = 0; i < cand_q.size() && i < int'(MAX_TRIES) && !found; i++) begin
      e.gens = i + 1;
      e.att  = 4'(i + 1);
      if (is_prime(int'(cand_q[i]))) begin
        found   = 1'b1;
        e.fail  = 1'b0;
        e.prime = cand_q[i];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gen_enable !== 1'b0) begin failures++; $display("FAIL reset_gen_enable: got %b expected 0", gen_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (fail !== 1'b0) begin failures++; $display("FAIL reset_fail: got %b expected 0", fail); end
    checks++; if (prime !== 7'd0) begin failures++; $display("FAIL reset_prime: got %0d expected 0", prime); end
`ifdef PRIME_SEARCH_STATS_EN
    checks++; if (attempts !== 4'd0) begin failures++; $display("FAIL reset_attempts: got %0d expected 0", attempts); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_single_prime();
    bit seen; exp_t e; int g0;
    cand_q.push_back(7'd97);
    push_expected();
    g0 = gen_count;
    pulse_start();
    checks++; if (gen_enable !== 1'b1) begin failures++; $display("FAIL single_latency: gen_enable got %b expected 1", gen_enable); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_done(2000, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL single_done: done not seen within budget"); end
    else begin
      if (fail !== e.fail) begin failures++; $display("FAIL single_fail: got %b expected %b", fail, e.fail); end
      checks++; if (prime !== e.prime) begin failures++; $display("FAIL single_prime: got %0d expected %0d", prime, e.prime); end
      checks++; if (gen_count - g0 !== e.gens) begin failures++; $display("FAIL single_gens: got %0d expected %0d", gen_count - g0, e.gens); end
    end
  endtask

  task automatic test_multi(input string name, input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2);
    bit seen; exp_t e; int g0;
    cand_q.push_back(c0); cand_q.push_back(c1); cand_q.push_back(c2);
    push_expected();
    g0 = gen_count;
    pulse_start();
    wait_done(3000, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL %s_done: done not seen within budget", name); end
    else begin
      if (fail !== e.fail) begin failures++; $display("FAIL %s_fail: got %b expected %b", name, fail, e.fail); end
      checks++; if (prime !== e.prime) begin failures++; $display("FAIL %s_prime: got %0d expected %0d", name, prime, e.prime); end
      checks++; if (gen_count - g0 !== e.gens) begin failures++; $display("FAIL %s_gens: got %0d expected %0d", name, gen_count - g0, e.gens); end
`ifdef PRIME_SEARCH_STATS_EN
      checks++; if (attempts !== e.att) begin failures++; $display("FAIL %s_attempts: got %0d expected %0d", name, attempts, e.att); end
`endif
    end
    cand_q.delete();
  endtask

  // 0 and 1 leave CHECK after one cycle, and 2 is prime on the first divisor
  task automatic test_small_reject();
    bit seen; exp_t e; int n;
    cand_q.push_back(7'd0); cand_q.push_back(7'd1); cand_q.push_back(7'd2);
    push_expected();
    pulse_start();
    wait_done(500, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL small_done: done not seen within budget"); end
    else begin
      n = gen_cyc.size();
      if (prime !== e.prime || fail !== e.fail) begin failures++; $display("FAIL small_result: got prime=%0d fail=%b expected prime=%0d fail=%b", prime, fail, e.prime, e.fail); end
      checks++; if (gen_cyc[n-2] - gen_cyc[n-3] !== 5) begin failures++; $display("FAIL small_gap0: got %0d cycles expected 5", gen_cyc[n-2] - gen_cyc[n-3]); end
      checks++; if (gen_cyc[n-1] - gen_cyc[n-2] !== 5) begin failures++; $display("FAIL small_gap1: got %0d cycles expected 5", gen_cyc[n-1] - gen_cyc[n-2]); end
      checks++; if (cyc - gen_cyc[n-1] !== 4) begin failures++; $display("FAIL small_two_latency: got %0d cycles expected 4", cyc - gen_cyc[n-1]); end
    end
  endtask

  task automatic test_small_primes();
    logic [6:0] pr [6] = '{7'd2, 7'd3, 7'd5, 7'd7, 7'd11, 7'd13};
    bit seen; exp_t e;
    foreach (pr[i]) begin
      cand_q.push_back(pr[i]);
      push_expected();
      pulse_start();
      wait_done(500, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || prime !== e.prime || fail !== e.fail) begin
        failures++;
        $display("FAIL small_prime_%0d: got seen=%b prime=%0d fail=%b expected prime=%0d fail=%b", pr[i], seen, prime, fail, e.prime, e.fail);
      end
    end
  endtask

  task automatic test_exhaust();
    logic [6:0] comp [8] = '{7'd4, 7'd6, 7'd8, 7'd9, 7'd10, 7'd12, 7'd14, 7'd15};
    bit seen; exp_t e; int g0;
    foreach (comp[i]) cand_q.push_back(comp[i]);
    push_expected();
    g0 = gen_count;
    pulse_start();
    wait_done(3000, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL exhaust_done: done not seen within budget"); end
    else begin
      if (fail !== e.fail) begin failures++; $display("FAIL exhaust_fail: got %b expected %b", fail, e.fail); end
      checks++; if (prime !== e.prime) begin failures++; $display("FAIL exhaust_prime: got %0d expected %0d", prime, e.prime); end
      checks++; if (gen_count - g0 !== e.gens) begin failures++; $display("FAIL exhaust_gens: got %0d expected %0d", gen_count - g0, e.gens); end
`ifdef PRIME_SEARCH_STATS_EN
      checks++; if (attempts !== e.att) begin failures++; $display("FAIL exhaust_attempts: got %0d expected %0d", attempts, e.att); end
`endif
    end
  endtask

  // Generator silent: done must arrive WAIT_LIMIT cycles after WAIT is entered
  task automatic test_timeout();
    bit seen; exp_t e; int t0;
    e.fail = 1'b1; e.prime = '0; e.gens = 1; e.att = 4'd1;
    exp_q.push_back(e);
    gen_respond = 1'b0;
    pulse_start();
    t0 = cyc;
    wait_done(200, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin failures++; $display("FAIL timeout_done: done not seen within budget"); end
    else begin
      if (cyc - t0 !== int'(WAIT_LIMIT) + 1) begin failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d", cyc - t0, WAIT_LIMIT + 1); end
      checks++; if (fail !== e.fail || prime !== e.prime) begin failures++; $display("FAIL timeout_result: got fail=%b prime=%0d expected fail=%b prime=%0d", fail, prime, e.fail, e.prime); end
`ifdef PRIME_SEARCH_STATS_EN
      checks++; if (attempts !== e.att) begin failures++; $display("FAIL timeout_attempts: got %0d expected %0d", attempts, e.att); end
`endif
    end
    gen_respond = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_check();
    bit seen; exp_t e; int g0;
    cand_q.push_back(7'd127);
    pulse_start();
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midcheck_busy: got %b expected 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gen_enable, busy, done, fail, prime} !== 11'd0) begin
      failures++;
      $display("FAIL midcheck_reset_outputs: got gen=%b busy=%b done=%b fail=%b prime=%0d expected all 0", gen_enable, busy, done, fail, prime);
    end
`ifdef PRIME_SEARCH_STATS_EN
    checks++; if (attempts !== 4'd0) begin failures++; $display("FAIL midcheck_attempts: got %0d expected 0", attempts); end
`endif
    cand_q.delete();
    cand_q.push_back(7'd13);
    push_expected();
    g0    = gen_count;
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (gen_enable !== 1'b1) begin failures++; $display("FAIL post_reset_start: gen_enable got %b expected 1", gen_enable); end
    wait_done(1000, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || prime !== e.prime || fail !== e.fail || gen_count - g0 !== e.gens) begin
      failures++;
      $display("FAIL post_reset_search: got seen=%b prime=%0d fail=%b gens=%0d expected prime=%0d fail=%b gens=%0d", seen, prime, fail, gen_count - g0, e.prime, e.fail, e.gens);
    end
  endtask

  task automatic test_start_ignored();
    bit seen; exp_t e; int g0;
    cand_q.push_back(7'd97);
    push_expected();
    g0 = gen_count;
    pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || prime !== e.prime || fail !== e.fail) begin
      failures++;
      $display("FAIL ignored_result: got seen=%b prime=%0d fail=%b expected prime=%0d fail=%b", seen, prime, fail, e.prime, e.fail);
    end
    repeat (5) @(negedge clk);
    checks++; if (gen_count - g0 !== 1) begin failures++; $display("FAIL ignored_gens: got %0d expected 1", gen_count - g0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_idle: busy got %b expected 0", busy); end
    checks++; if (prime !== 7'd97) begin failures++; $display("FAIL ignored_hold: prime got %0d expected 97", prime); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    test_reset();
    test_single_prime();
    test_multi("multi", 7'd100, 7'd91, 7'd53);
    test_multi("div11", 7'd121, 7'd49, 7'd127);
    test_small_reject();
    test_small_primes();
    test_exhaust();
    test_timeout();
    test_reset_mid_check();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prime_search_controller.md
PRIME_SEARCH_CONTROLLER -- requirements
Module: prime_search_controller

Interface
REQ-001 Parameter MAX_TRIES, default 8, SHALL set the maximum number of candidates tested per search (range 1..15).
REQ-002 Parameter WAIT_LIMIT, default 16, SHALL set the number of cycles to wait for a candidate before aborting.
REQ-003 clk  input  1  clock; all logic SHALL be triggered on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  single-cycle search request; SHALL be sampled only in IDLE.
REQ-006 gen_enable  output  1  SHALL drive the random-generator enable input.
REQ-007 cand_valid  input  1  SHALL carry the generator's candidate-ready pulse.
REQ-008 cand  input  7  SHALL carry the generator's candidate number, stable while cand_valid=1.
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking the end of a search.
REQ-011 fail  output  1  SHALL be valid with done; 1 means no prime found or timeout.
REQ-012 prime  output  7  SHALL be the found prime, held from done until the next start.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, WAIT, CHECK, NEXT and FIN.
REQ-014 IDLE->REQ: on start=1; tries is cleared, and prime and fail are cleared.
REQ-015 REQ: gen_enable SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT; tries increments by 1.
REQ-016 WAIT: on cand_valid=1, cand SHALL be captured into num, with d=2 and rem=num, and the FSM SHALL go to CHECK.
REQ-017 WAIT timeout: after WAIT_LIMIT cycles without cand_valid, the FSM SHALL go to FIN with fail=1.
REQ-018 CHECK: num<2 SHALL be declared composite immediately, with no division cycles.
REQ-019 CHECK trial division: the divisor sequence SHALL be 2,3,5,7,11 (covers sqrt(127)); one subtraction per cycle, rem<=rem-d, while rem>=d.
REQ-020 When rem<d and rem==0 and num!=d: composite, go to NEXT.
REQ-021 When rem<d and rem!=0 (or num==d): advance to the next divisor and reload rem=num; after d=11 passes, num is prime: prime<=num, fail<=0, go to FIN.
REQ-022 When num==d: prime immediately; 2, 3, 5, 7 and 11 SHALL be reported prime.
REQ-023 NEXT: if tries==MAX_TRIES, fail<=1, prime<=0 and go to FIN; else go to REQ.
REQ-024 FIN: done=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 cand_valid SHALL be ignored outside WAIT.
REQ-027 Arithmetic: rem and num SHALL be 7-bit unsigned; no subtraction SHALL occur when rem<d (no underflow).
REQ-028 Latency: start to gen_enable SHALL be 1 cycle.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, gen_enable=0, busy=0, done=0, fail=0, prime=0, tries=0 and num=0, regardless of current state (including mid-CHECK).
REQ-030 The first start SHALL be accepted on the first edge after rst returns to 1.

Configuration
REQ-031 Macro PRIME_SEARCH_STATS_EN defined: adds output attempts [3:0] equal to tries, latched at done, reset to 0, held until the next start.
REQ-032 Macro PRIME_SEARCH_STATS_EN undefined: no attempts port and no latch register; all other behaviour identical.

Verification
REQ-033 Generator model returns 97 with cand_valid 2 cycles after gen_enable -> done=1, fail=0, prime=97, one gen_enable pulse.
REQ-034 Candidates 100, 91, 53 -> three gen_enable pulses, done with prime=53, fail=0, attempts=3 (stats build).
REQ-035 Candidates 0, 1, 2 -> 0 and 1 rejected with no division cycles; search ends with prime=2.
REQ-036 Eight composite candidates (e.g., 4, 6, 8, 9, 10, 12, 14, 15) with MAX_TRIES=8 -> done, fail=1, prime=0.
REQ-037 cand_valid held low after gen_enable -> done with fail=1 exactly WAIT_LIMIT cycles after entering WAIT.
REQ-038 rst=0 during CHECK with num=127 -> next cycle all outputs are 0 and the state is IDLE; a start pulse during busy produces no extra gen_enable.
